regfile: RTL and testbench



---
 rtl/openmips_pkg.sv | 12 +
 rtl/regfile_rport.sv | 37 +++
 rtl/regfile.sv | 71 +++++++
 tb/tb_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/openmips_pkg.sv
// Shared OpenMIPS constants: zero word, null register address and the
// register-file geometry defaults.
package openmips_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic [31:0] ZeroWord   = 32'h0;
  localparam logic [4:0]  NopRegAddr = 5'd0;

endpackage

// File: rtl/regfile_rport.sv
// One read port of the register file: reset/enable/zero-register gating,
// optional write-to-read forwarding (REGFILE_BYPASS_EN), then the array mux.
module regfile_rport #(
  parameter int RegBus     = openmips_pkg::RegBus,
  parameter int RegAddrBus = openmips_pkg::RegAddrBus,
  parameter int RegNum     = openmips_pkg::RegNum
) (
  input  logic                  i_rst_n,
  input  logic                  i_re,
  input  logic [RegAddrBus-1:0] i_raddr,
  input  logic [RegBus-1:0]     i_regs [RegNum],
`ifdef REGFILE_BYPASS_EN
  input  logic                  i_we,
  input  logic [RegAddrBus-1:0] i_waddr,
  input  logic [RegBus-1:0]     i_wdata,
`endif
  output logic [RegBus-1:0]     o_rdata
);
  import openmips_pkg::*;

  always_comb begin
    o_rdata = RegBus'(ZeroWord);
    if (i_rst_n && i_re && (i_raddr != RegAddrBus'(NopRegAddr))) begin
`ifdef REGFILE_BYPASS_EN
      // Forward the value being written this cycle so decode never sees stale data.
      if (i_we && (i_waddr == i_raddr)) begin
        o_rdata = i_wdata;
      end else begin
        o_rdata = i_regs[i_raddr];
      end
`else
      o_rdata = i_regs[i_raddr];
`endif
    end
  end

endmodule

// File: rtl/regfile.sv
// OpenMIPS general-purpose register file: 32x32, r0 hard-wired to zero,
// two combinational read ports, one clocked write port. Optional
// same-cycle forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int RegBus     = openmips_pkg::RegBus,
  parameter int RegAddrBus = openmips_pkg::RegAddrBus,
  parameter int RegNum     = openmips_pkg::RegNum
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [RegAddrBus-1:0] waddr_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic                  re1_i,
  input  logic [RegAddrBus-1:0] raddr1_i,
  output logic [RegBus-1:0]     rdata1_o,
  input  logic                  re2_i,
  input  logic [RegAddrBus-1:0] raddr2_i,
  output logic [RegBus-1:0]     rdata2_o
);
  import openmips_pkg::*;

  logic [RegBus-1:0] r_regs [RegNum];
  logic              w_wr_en;

  // Writes to r0 are dropped here, so entry 0 stays at its reset value of zero.
  assign w_wr_en = we_i && (waddr_i != RegAddrBus'(NopRegAddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
    end else if (w_wr_en) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  regfile_rport #(
    .RegBus    (RegBus),
    .RegAddrBus(RegAddrBus),
    .RegNum    (RegNum)
  ) u_rport1 (
    .i_rst_n(rst_n),
    .i_re   (re1_i),
    .i_raddr(raddr1_i),
    .i_regs (r_regs),
`ifdef REGFILE_BYPASS_EN
    .i_we   (we_i),
    .i_waddr(waddr_i),
    .i_wdata(wdata_i),
`endif
    .o_rdata(rdata1_o)
  );

  regfile_rport #(
    .RegBus    (RegBus),
    .RegAddrBus(RegAddrBus),
    .RegNum    (RegNum)
  ) u_rport2 (
    .i_rst_n(rst_n),
    .i_re   (re2_i),
    .i_raddr(raddr2_i),
    .i_regs (r_regs),
`ifdef REGFILE_BYPASS_EN
    .i_we   (we_i),
    .i_waddr(waddr_i),
    .i_wdata(wdata_i),
`endif
    .o_rdata(rdata2_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed and random checks of regfile against a simple array reference model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        re1_i = 1'b0;
  logic [4:0]  raddr1_i = '0;
  logic        re2_i = 1'b0;
  logic [4:0]  raddr2_i = '0;
  logic [31:0] rdata1_o;
  logic [31:0] rdata2_o;

  regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_i),
    .waddr_i (waddr_i),
    .wdata_i (wdata_i),
    .re1_i   (re1_i),
    .raddr1_i(raddr1_i),
    .rdata1_o(rdata1_o),
    .re2_i   (re2_i),
    .raddr2_i(raddr2_i),
    .rdata2_o(rdata2_o)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [31:0] model [32];
  int n_err = 0;
  int n_chk = 0;

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (!rst_n || !re || a == 5'd0) return 32'h0;
    if (Bypass && we_i && waddr_i == a) return wdata_i;
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_p1"}, rdata1_o, exp_read(re1_i, raddr1_i));
    chk({tag, "_p2"}, rdata2_o, exp_read(re2_i, raddr2_i));
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    we_i = w; waddr_i = wa; wdata_i = wd;
    re1_i = r1; raddr1_i = a1;
    re2_i = r2; raddr2_i = a2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Commit the write the DUT sees at this edge, then move off the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we_i && waddr_i != 5'd0) model[waddr_i] = wdata_i;
    #1;
  endtask

  initial begin
    logic [4:0] wa, a1, a2;
    model_clear();

    // Reset with both ports enabled.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    #3;
    chk("rst_p1", rdata1_o, 32'h0);
    chk("rst_p2", rdata2_o, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(2*i), 1'b1, 5'(2*i+1));
      #3;
      chk("post_rst_p1", rdata1_o, 32'h0);
      chk("post_rst_p2", rdata2_o, 32'h0);
      tick();
    end

    // Basic write then read on both ports.
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    #3; tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);
    #3;
    chk("r3_p1", rdata1_o, 32'hDEADBEEF);
    chk("r3_p2", rdata2_o, 32'hDEADBEEF);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
    #3;
    chk("r3_p1_keep", rdata1_o, 32'hDEADBEEF);
    chk("re2_off", rdata2_o, 32'h0);
    tick();

    // Write to r0 is dropped and must not alias another entry.
    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0);
    #3;
    chk("r0_wr_p1", rdata1_o, 32'h0);
    chk("r0_wr_p2", rdata2_o, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    #3;
    chk("r0_rd_p1", rdata1_o, 32'h0);
    chk("r0_rd_p2", rdata2_o, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(2*i), 1'b1, 5'(2*i+1));
      #3;
      check_ports("alias");
      tick();
    end

    // Same-cycle write and read of r7.
    drive(1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 1'b0, 5'd0);
    #3; tick();
    drive(1'b1, 5'd7, 32'h2222_2222, 1'b1, 5'd7, 1'b1, 5'd7);
    #3;
    chk("hazard_p1", rdata1_o, Bypass ? 32'h2222_2222 : 32'h1111_1111);
    check_ports("hazard");
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
    #3;
    chk("hazard_next", rdata1_o, 32'h2222_2222);
    tick();

    // Reset pulsed between edges, with a write held across an edge in reset.
    drive(1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    #3; tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1, 5'd10);
    #3;
    chk("r10_pre", rdata1_o, 32'hA5A5A5A5);
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("r10_async_p1", rdata1_o, 32'h0);
    chk("r10_async_p2", rdata2_o, 32'h0);
    drive(1'b1, 5'd11, 32'hCAFEF00D, 1'b1, 5'd11, 1'b1, 5'd10);
    tick();
    #1 rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1, 5'd11);
    #2;
    chk("r10_after", rdata1_o, 32'h0);
    chk("r11_lost", rdata2_o, 32'h0);
    tick();

    // Random sweep with forced address collisions and r0 traffic.
    for (int n = 0; n < 2000; n++) begin
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       a2 = wa;
        1:       a2 = a1;
        default: a2 = 5'($urandom_range(0, 31));
      endcase
      drive($urandom_range(0, 3) != 0, wa, $urandom,
            $urandom_range(0, 7) != 0, a1,
            $urandom_range(0, 7) != 0, a2);
      #3;
      check_ports("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
